aggregate_cost_top: RTL and testbench
=====================================

# aggregate_cost_top

Single-direction (left-to-right, horizontal) SGM cost-aggregation stage of the SGBM stereo pipeline. Accepts one pixel per clock in raster order, carrying a packed vector of 96 initial matching costs, and produces the path-aggregated cost vector. Built from an input delay/register stage (`delay_aggr`) followed by the aggregation core (`aggregate_cost`). The core's registered output is fed back internally as the previous-pixel cost.

## Interface
- `DISP`, 96: disparity lanes per pixel.
- `CW`, 9: bits per cost lane; `DISP*CW` = 864.
- `P1`, 10: small penalty for a ±1 disparity change.
- `P2`, 120: large penalty for any disparity jump; `P2 < 2**CW-1`.
- `DELAY`, 1: register stages in `delay_aggr`, ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous reset, active-low.
- `en`  in  1  input pixel valid.
- `cost_init`  in  864  initial costs; lane d at bits [CW*d+CW-1 : CW*d].
- `row`  in  10  pixel row.
- `col`  in  10  pixel column; 0 = start of a path.
- `cost_aggr`  out  864  aggregated costs, same packing.
- `out_row`  out  10  row of the output pixel.
- `out_col`  out  10  column of the output pixel.
- `valid`  out  1  output pixel valid.

## Operation
- `delay_aggr` delays `cost_init`, `row`, `col` and `en` through `DELAY` registers without changing them. Its `valid` output is the delayed `en`.
- `aggregate_cost` processes each pixel whose delayed valid is high. C is the pixel's cost and Lp is the current `cost_aggr` register, which holds the last accepted pixel.
- When `col == 0`: L(d) = C(d).
- Otherwise:
  - m = min over all d of Lp(d).
  - L(d) = C(d) + min(Lp(d), Lp(d-1)+P1, Lp(d+1)+P1, m+P2) − m.
  - At d=0 and d=DISP-1, the out-of-range neighbour term is omitted.
- Arithmetic:
  - Intermediate width is CW+2, unsigned.
  - The subtraction cannot underflow, since every candidate is ≥ m.
  - The result saturates to 2**CW−1 (511).
- Pixels are in raster order. Lp is always the previously accepted pixel, so the row change to col 0 restarts the path.
- Bubbles are allowed: when `en` is low, Lp is held and nothing is computed.

## Timing
- Latency from `en` sample to `valid` is DELAY+1 cycles (default 2). Throughput is one pixel per clock.
- `cost_aggr`, `out_row` and `out_col` update only in cycles where `valid` is asserted. Otherwise they hold, and `valid` is 0.
- The aggregation is single-cycle: combinational min/add tree, then a register. This is required so that back-to-back pixels use the immediately preceding result.
- Reset (`rst`=0 at a clock edge) forces all pipeline registers and outputs to 0, clears all valids, and discards in-flight pixels.
- Reset mid-frame: the first pixel after release must be col 0. Otherwise it aggregates against Lp = 0.
- No backpressure; the consumer must accept every `valid` cycle.

## Structure
- Shared package holds the `DISP`, `CW`, `P1`, `P2` defaults and the row/col width (10).
- Sub-module `delay_aggr`: parameterised shift register for data, row, col and valid.
- `aggregate_cost` contains:
  - the 96-lane min-reduction tree;
  - per-lane 4-way min, add/subtract and saturate;
  - the output register.

## Test plan
- Reset: hold `rst`=0 with `en`=1 and random data → `valid`=0, `cost_aggr`=0, `out_row`=`out_col`=0.
- Path start: (row 3, col 0), C(d)=d → two cycles later `valid`=1, `cost_aggr` lane d = d, `out_row`=3, `out_col`=0.
- Flat costs: col 0 then col 1, all C=5 → second output all lanes 5.
- Penalties: Lp(10)=0 and all other lanes 100; next pixel col 1 with C=0 → L(10)=0, L(9)=L(11)=10, L(50)=100.
- Saturation: Lp(0)=0, other lanes 300; C=511 at col 1 → L(50)=511 (631 saturated), L(0)=511, L(1)=511.
- Bubble and row wrap:
  - one idle `en` cycle between col 1 and col 2 → same results as gapless, with one `valid`=0 cycle;
  - col 399 followed by (row+1, col 0) → output equals C.

Source files
------------

// File: rtl/aggregate_cost_pkg.sv
// Shared defaults for the horizontal SGM aggregation stage: lane count,
// cost width, penalties and the row/column coordinate width.
package aggregate_cost_pkg;

   localparam int DISP_DEF  = 96;
   localparam int CW_DEF    = 9;
   localparam int P1_DEF    = 10;
   localparam int P2_DEF    = 120;
   localparam int DELAY_DEF = 1;
   localparam int RC_W      = 10;

   typedef logic [RC_W-1:0] rc_t;

   // Smallest power of two >= n, sizes the min-reduction tree.
   function automatic int pow2_ceil(input int n);
      int p;
      p = 1;
      while (p < n) p = p * 2;
      return p;
   endfunction

endpackage

// File: rtl/aggregate_cost.sv
// Single-cycle SGM path aggregation: min over the previous pixel's costs,
// per-lane 4-way penalty min, add/subtract, saturate, then register.
module aggregate_cost
   import aggregate_cost_pkg::*;
#(
   parameter int DISP = DISP_DEF,
   parameter int CW   = CW_DEF,
   parameter int P1   = P1_DEF,
   parameter int P2   = P2_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [DISP*CW-1:0] cost_in,
   input  rc_t                row_in,
   input  rc_t                col_in,
   output logic [DISP*CW-1:0] cost_aggr,
   output rc_t                out_row,
   output rc_t                out_col,
   output logic               valid
);

   localparam int IW     = CW + 2;
   localparam int TREE_N = pow2_ceil(DISP);
   localparam logic [IW-1:0] P1_W  = IW'(P1);
   localparam logic [IW-1:0] P2_W  = IW'(P2);
   localparam logic [IW-1:0] MAX_W = IW'((1 << CW) - 1);

   logic [CW-1:0]      lp     [DISP];
   logic [CW-1:0]      c      [DISP];
   logic [CW-1:0]      tree   [TREE_N];
   logic [IW-1:0]      m_w;
   logic [DISP*CW-1:0] cost_next;

   always_comb begin
      for (int d = 0; d < DISP; d++) begin
         lp[d] = cost_aggr[d*CW +: CW];
         c[d]  = cost_in[d*CW +: CW];
      end
   end

   // Pairwise reduction; pad lanes are all-ones so they never win.
   always_comb begin
      for (int i = 0; i < TREE_N; i++) begin
         tree[i] = (i < DISP) ? cost_aggr[i*CW +: CW] : '1;
      end
      for (int n = TREE_N / 2; n >= 1; n = n / 2) begin
         for (int i = 0; i < n; i++) begin
            tree[i] = (tree[2*i] < tree[2*i+1]) ? tree[2*i] : tree[2*i+1];
         end
      end
      m_w = IW'(tree[0]);
   end

   always_comb begin
      logic [IW-1:0] best;
      logic [IW-1:0] cand;
      logic [IW-1:0] sum;
      cost_next = '0;
      best      = '0;
      cand      = '0;
      sum       = '0;
      for (int d = 0; d < DISP; d++) begin
         best = IW'(lp[d]);
         if (d > 0) begin
            cand = IW'(lp[d-1]) + P1_W;
            if (cand < best) best = cand;
         end
         if (d < DISP - 1) begin
            cand = IW'(lp[d+1]) + P1_W;
            if (cand < best) best = cand;
         end
         cand = m_w + P2_W;
         if (cand < best) best = cand;
         // best >= m always, so the subtraction stays non-negative.
         sum = IW'(c[d]) + best - m_w;
         if (col_in == '0) begin
            cost_next[d*CW +: CW] = c[d];
         end else if (sum > MAX_W) begin
            cost_next[d*CW +: CW] = '1;
         end else begin
            cost_next[d*CW +: CW] = sum[CW-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cost_aggr <= '0;
         out_row   <= '0;
         out_col   <= '0;
         valid     <= 1'b0;
      end else begin
         valid <= in_valid;
         if (in_valid) begin
            cost_aggr <= cost_next;
            out_row   <= row_in;
            out_col   <= col_in;
         end
      end
   end

endmodule

// File: rtl/delay_aggr.sv
// Input register stage: delays cost vector, coordinates and pixel valid by
// DELAY clocks without modifying them.
module delay_aggr
   import aggregate_cost_pkg::*;
#(
   parameter int DELAY = DELAY_DEF,
   parameter int DW    = DISP_DEF * CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [DW-1:0] data,
   input  rc_t           row,
   input  rc_t           col,
   output logic [DW-1:0] data_d,
   output rc_t           row_d,
   output rc_t           col_d,
   output logic          valid
);

   logic [DW-1:0] data_sr  [DELAY];
   rc_t           row_sr   [DELAY];
   rc_t           col_sr   [DELAY];
   logic          valid_sr [DELAY];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DELAY; i++) begin
            data_sr[i]  <= '0;
            row_sr[i]   <= '0;
            col_sr[i]   <= '0;
            valid_sr[i] <= 1'b0;
         end
      end else begin
         data_sr[0]  <= data;
         row_sr[0]   <= row;
         col_sr[0]   <= col;
         valid_sr[0] <= en;
         for (int i = 1; i < DELAY; i++) begin
            data_sr[i]  <= data_sr[i-1];
            row_sr[i]   <= row_sr[i-1];
            col_sr[i]   <= col_sr[i-1];
            valid_sr[i] <= valid_sr[i-1];
         end
      end
   end

   assign data_d = data_sr[DELAY-1];
   assign row_d  = row_sr[DELAY-1];
   assign col_d  = col_sr[DELAY-1];
   assign valid  = valid_sr[DELAY-1];

endmodule

// File: rtl/aggregate_cost_top.sv
// Left-to-right SGM cost aggregation: input delay stage feeding the
// aggregation core, whose registered output is the previous-pixel cost.
module aggregate_cost_top
   import aggregate_cost_pkg::*;
#(
   parameter int DISP  = DISP_DEF,
   parameter int CW    = CW_DEF,
   parameter int P1    = P1_DEF,
   parameter int P2    = P2_DEF,
   parameter int DELAY = DELAY_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [DISP*CW-1:0] cost_init,
   input  logic [RC_W-1:0]    row,
   input  logic [RC_W-1:0]    col,
   output logic [DISP*CW-1:0] cost_aggr,
   output logic [RC_W-1:0]    out_row,
   output logic [RC_W-1:0]    out_col,
   output logic               valid
);

   // Valid-only streaming: en qualifies the inputs in the cycle it is high and
   // valid qualifies the outputs; there is no ready, every valid beat is taken.
   logic [DISP*CW-1:0] cost_d;
   rc_t                row_d;
   rc_t                col_d;
   logic               valid_d;

   delay_aggr #(
      .DELAY (DELAY),
      .DW    (DISP * CW)
   ) u_delay (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .data   (cost_init),
      .row    (row),
      .col    (col),
      .data_d (cost_d),
      .row_d  (row_d),
      .col_d  (col_d),
      .valid  (valid_d)
   );

   aggregate_cost #(
      .DISP (DISP),
      .CW   (CW),
      .P1   (P1),
      .P2   (P2)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (valid_d),
      .cost_in   (cost_d),
      .row_in    (row_d),
      .col_in    (col_d),
      .cost_aggr (cost_aggr),
      .out_row   (out_row),
      .out_col   (out_col),
      .valid     (valid)
   );

endmodule

// File: tb/tb_aggregate_cost_top.sv
// Directed table-driven bench for aggregate_cost_top with hand-derived
// expected cost vectors and a few multi-cycle reset sequences.
module tb_aggregate_cost_top;

   localparam int DISP = 96;
   localparam int CW   = 9;
   localparam int W    = DISP * CW;
   localparam int NV   = 14;

   typedef struct {
      logic         en;
      logic [9:0]   row;
      logic [9:0]   col;
      logic [W-1:0] cost;
      logic         exp_valid;
      logic [9:0]   exp_row;
      logic [9:0]   exp_col;
      logic [W-1:0] exp_cost;
   } vec_t;

   logic         clk;
   logic         rst;
   logic         en;
   logic [W-1:0] cost_init;
   logic [9:0]   row;
   logic [9:0]   col;
   logic [W-1:0] cost_aggr;
   logic [9:0]   out_row;
   logic [9:0]   out_col;
   logic         valid;

   vec_t         tab [NV];
   logic [W-1:0] exp_q [$];
   int           total;
   int           bad;

   aggregate_cost_top dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .cost_init (cost_init),
      .row       (row),
      .col       (col),
      .cost_aggr (cost_aggr),
      .out_row   (out_row),
      .out_col   (out_col),
      .valid     (valid)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [W-1:0] flat(input int v);
      logic [W-1:0] r;
      for (int d = 0; d < DISP; d++) r[d*CW +: CW] = CW'(v);
      return r;
   endfunction

   function automatic logic [W-1:0] ramp(input int mul);
      logic [W-1:0] r;
      for (int d = 0; d < DISP; d++) r[d*CW +: CW] = CW'(mul * d);
      return r;
   endfunction

   function automatic logic [W-1:0] set_lane(input logic [W-1:0] base, input int d, input int v);
      logic [W-1:0] r;
      r = base;
      r[d*CW +: CW] = CW'(v);
      return r;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic drive(input logic e, input logic [9:0] r, input logic [9:0] c, input logic [W-1:0] v);
      en        = e;
      row       = r;
      col       = c;
      cost_init = v;
   endtask

   task automatic set_vec(input int k, input logic e, input int r, input int c, input logic [W-1:0] v,
                          input logic ev, input int er, input int ec, input logic [W-1:0] ex);
      tab[k].en        = e;
      tab[k].row       = 10'(r);
      tab[k].col       = 10'(c);
      tab[k].cost      = v;
      tab[k].exp_valid = ev;
      tab[k].exp_row   = 10'(er);
      tab[k].exp_col   = 10'(ec);
      tab[k].exp_cost  = ex;
   endtask

   initial begin
      logic [W-1:0] v, e5, e7, e12, e13, rnd;
      total = 0;
      bad   = 0;

      // Penalty patterns, derived by hand from the recurrence.
      v  = set_lane(flat(100), 10, 0);
      e5 = set_lane(set_lane(v, 9, 10), 11, 10);
      e7 = set_lane(set_lane(e5, 8, 20), 12, 20);
      for (int d = 0; d < DISP; d++) begin
         e12[d*CW +: CW] = CW'((3 * d < 120) ? 3 * d : 120);
         e13[d*CW +: CW] = CW'((d <= 40) ? 4 * d : d + 120);
      end

      set_vec(0,  1, 3, 0,   ramp(1),                      1, 3, 0,   ramp(1));
      set_vec(1,  1, 3, 1,   flat(5),                      1, 3, 1,   ramp(1) + flat(5));
      set_vec(2,  1, 4, 0,   flat(5),                      1, 4, 0,   flat(5));
      set_vec(3,  1, 4, 1,   flat(5),                      1, 4, 1,   flat(5));
      set_vec(4,  1, 5, 0,   v,                            1, 5, 0,   v);
      set_vec(5,  1, 5, 1,   flat(0),                      1, 5, 1,   e5);
      set_vec(6,  0, 9, 9,   flat(77),                     0, 5, 1,   e5);
      set_vec(7,  1, 5, 2,   flat(0),                      1, 5, 2,   e7);
      set_vec(8,  1, 6, 0,   set_lane(flat(300), 0, 0),    1, 6, 0,   set_lane(flat(300), 0, 0));
      set_vec(9,  1, 6, 1,   flat(511),                    1, 6, 1,   flat(511));
      set_vec(10, 1, 6, 399, flat(7),                      1, 6, 399, flat(7));
      set_vec(11, 1, 7, 0,   ramp(3),                      1, 7, 0,   ramp(3));
      set_vec(12, 1, 7, 1,   flat(0),                      1, 7, 1,   e12);
      set_vec(13, 1, 7, 2,   ramp(1),                      1, 7, 2,   e13);

      // Reset held with random traffic.
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         for (int d = 0; d < DISP; d++) rnd[d*CW +: CW] = CW'($urandom_range(0, 511));
         drive(1'b1, 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), rnd);
         @(negedge clk);
      end
      chk("rst_valid", W'(valid), W'(1'b0));
      chk("rst_cost", cost_aggr, '0);
      chk("rst_row", W'(out_row), '0);
      chk("rst_col", W'(out_col), '0);
      drive(1'b0, '0, '0, '0);
      @(negedge clk);
      rst = 1'b1;

      // Table: vector k is checked two clocks after it is driven.
      for (int k = 0; k < NV + 2; k++) begin
         @(negedge clk);
         if (k >= 2) begin
            chk($sformatf("v%0d_valid", k - 2), W'(valid), W'(tab[k-2].exp_valid));
            chk($sformatf("v%0d_row", k - 2), W'(out_row), W'(tab[k-2].exp_row));
            chk($sformatf("v%0d_col", k - 2), W'(out_col), W'(tab[k-2].exp_col));
            chk($sformatf("v%0d_cost", k - 2), cost_aggr, exp_q.pop_front());
         end
         if (k < NV) begin
            drive(tab[k].en, tab[k].row, tab[k].col, tab[k].cost);
            exp_q.push_back(tab[k].exp_cost);
         end else begin
            drive(1'b0, '0, '0, '0);
         end
      end

      // Mid-frame reset: in-flight pixel discarded, Lp cleared to 0.
      @(negedge clk);
      drive(1'b1, 10'd9, 10'd0, ramp(2));
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, '0, '0, '0);
      @(negedge clk);
      chk("mid_rst_valid", W'(valid), W'(1'b0));
      chk("mid_rst_cost", cost_aggr, '0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_discard", W'(valid), W'(1'b0));
      drive(1'b1, 10'd9, 10'd5, flat(4));
      @(negedge clk);
      drive(1'b0, '0, '0, '0);
      @(negedge clk);
      chk("post_rst_valid", W'(valid), W'(1'b1));
      chk("post_rst_cost", cost_aggr, flat(4));
      chk("post_rst_col", W'(out_col), W'(10'd5));
      @(negedge clk);
      chk("post_rst_hold_valid", W'(valid), W'(1'b0));
      chk("post_rst_hold_cost", cost_aggr, flat(4));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
